sec_arbiter: RTL and testbench
==============================

SEC_ARBITER -- requirements
Module: sec_arbiter

Parameters
REQ-001 SHALL provide parameter NBITSIN, default 16: operand width of the shared sequential unit.
REQ-002 SHALL provide parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL provide parameter TIMEOUT, default NBITSIN/2+16: maximum WAIT cycles before abort.

Interface
REQ-004 SHALL have port clock, input, 1: master clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, NREQ: level request per requester, held until its ack.
REQ-007 SHALL have port req_data, input, NREQ*NBITSIN: operand of requester i in bits [i*NBITSIN +: NBITSIN].
REQ-008 SHALL have port ack, output, NREQ: one-hot, one-cycle pulse; operand accepted.
REQ-009 SHALL have port res_valid, output, 1: one-cycle result pulse.
REQ-010 SHALL have port res_id, output, 3: requester index of the result.
REQ-011 SHALL have port res_data, output, NBITSIN/2: result value.
REQ-012 SHALL have port res_err, output, 1: high with res_valid when the operation timed out.
REQ-013 SHALL have port arb_busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port unit_run, output, 1: start pulse to the shared unit.
REQ-015 SHALL have port unit_din, output, NBITSIN: operand to the shared unit.
REQ-016 SHALL have port unit_busy, input, 1: shared unit busy.
REQ-017 SHALL have port unit_stop, input, 1: shared unit done pulse.
REQ-018 SHALL have port unit_dout, input, NBITSIN/2: shared unit result.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, WAIT and DRAIN; all outputs are registered.
REQ-020 In IDLE, when |req and !unit_busy: select grant g by round-robin, latch unit_din <= req_data[g], set ack[g] and unit_run to 1, go to RUN.
REQ-021 In IDLE, when unit_busy=1: no grant, remain in IDLE.
REQ-022 Round-robin: search starts at priority pointer p, wrapping NREQ-1 -> 0; after each grant, p <= (g+1) mod NREQ.
REQ-023 RUN lasts exactly one cycle: ack and unit_run are high only in RUN; timer <= 0; go to WAIT.
REQ-024 unit_din SHALL hold stable from RUN until the next grant.
REQ-025 In WAIT, on unit_stop=1: res_data <= unit_dout, res_id <= g, res_valid <= 1, res_err <= 0; go to DRAIN.
REQ-026 In WAIT without unit_stop: timer increments.
REQ-027 In WAIT, when timer reaches TIMEOUT-1 without unit_stop: res_valid <= 1, res_err <= 1, res_data <= 0, res_id <= g; go to DRAIN.
REQ-028 unit_stop and timeout in the same cycle: unit_stop wins, and res_err = 0.
REQ-029 res_valid and res_err SHALL be one-cycle pulses asserted on entry to DRAIN.
REQ-030 In DRAIN, wait for unit_busy=0, then go to IDLE; a grant is legal no earlier than the cycle after DRAIN exits.
REQ-031 unit_stop outside WAIT SHALL be ignored.
REQ-032 A requester dropping req after its ack SHALL NOT affect the operation in flight.
REQ-033 Minimum grant-to-grant spacing: 4 cycles (RUN, WAIT>=1, DRAIN>=1, IDLE).
REQ-034 The timer SHALL be wide enough for TIMEOUT and SHALL NOT wrap.

Reset
REQ-035 Reset SHALL give state=IDLE, p=0, timer=0, and ack, res_valid, res_id, res_data, res_err, arb_busy, unit_run, unit_din all 0.
REQ-036 Reset asserted in any state, including mid-WAIT, SHALL abort with no res_valid; the shared unit is expected to be reset by the same signal.

Verification
REQ-037 Single request: req=0001, data0=0x0051; unit model returns stop with dout=0x09 after 12 cycles -> ack=0001 and unit_run for 1 cycle, unit_din=0x0051, then res_valid=1, res_id=0, res_data=0x09, res_err=0.
REQ-038 Fairness: req=1111 held continuously -> grant order 0,1,2,3,0, and each ack occurs exactly once per operation.
REQ-039 Pointer: grant to 2, then req=0101 -> next grant is 0 (search order 3,0).
REQ-040 Timeout: unit never stops -> res_valid=1, res_err=1, res_data=0 exactly TIMEOUT cycles after entering WAIT (24 for defaults).
REQ-041 Busy block: unit_busy=1 in IDLE with req=0010 -> no ack until unit_busy=0, then ack=0010 on the next cycle.
REQ-042 Reset in WAIT: assert reset for 1 cycle -> all outputs 0 next cycle, no res_valid, next grant starts from requester 0.

Source files
------------

// File: rtl/sec_arbiter.sv
// rtl/sec_arbiter.sv - round-robin arbiter sharing one sequential unit among NREQ requesters
// Grants one operand at a time, waits for the unit's done pulse or a timeout, then reports the result.
module sec_arbiter #(
   parameter int NBITSIN = 16,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = NBITSIN/2 + 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*NBITSIN-1:0]   req_data,
   output logic [NREQ-1:0]           ack,
   output logic                      res_valid,
   output logic [2:0]                res_id,
   output logic [NBITSIN/2-1:0]      res_data,
   output logic                      res_err,
   output logic                      arb_busy,
   output logic                      unit_run,
   output logic [NBITSIN-1:0]        unit_din,
   input  logic                      unit_busy,
   input  logic                      unit_stop,
   input  logic [NBITSIN/2-1:0]      unit_dout
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, WAIT, DRAIN} state_t;

   state_t                 state, state_n;
   logic [2:0]             ptr, ptr_n;
   logic [2:0]             gnt, gnt_n;
   logic [TW-1:0]          timer, timer_n;
   logic [NREQ-1:0]        ack_n, onehot;
   logic                   run_n, rv_n, re_n, busy_n;
   logic [2:0]             rid_n;
   logic [NBITSIN/2-1:0]   rdata_n;
   logic [NBITSIN-1:0]     din_n, din_sel;
   logic [7:0]             req_pad;
   logic [3:0]             idx;
   logic [2:0]             sel;
   logic                   sel_ok;

   assign req_pad = 8'(req);

   // Scan downward so the last hit is the requester closest to ptr in wrap order.
   always_comb begin
      sel    = '0;
      sel_ok = 1'b0;
      idx    = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'(NREQ))
            idx = idx - 4'(NREQ);
         if (req_pad[idx[2:0]]) begin
            sel    = idx[2:0];
            sel_ok = 1'b1;
         end
      end
   end

   always_comb begin
      din_sel = '0;
      onehot  = '0;
      for (int i = 0; i < NREQ; i++) begin
         onehot[i] = (sel == 3'(i));
         if (sel == 3'(i))
            din_sel = req_data[i*NBITSIN +: NBITSIN];
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      gnt_n   = gnt;
      timer_n = timer;
      ack_n   = '0;
      run_n   = 1'b0;
      din_n   = unit_din;
      rv_n    = 1'b0;
      re_n    = 1'b0;
      rid_n   = res_id;
      rdata_n = res_data;
      case (state)
         IDLE: begin
            if (sel_ok && !unit_busy) begin
               ack_n   = onehot;
               run_n   = 1'b1;
               din_n   = din_sel;
               gnt_n   = sel;
               ptr_n   = (sel == 3'(NREQ-1)) ? 3'd0 : sel + 3'd1;
               state_n = RUN;
            end
         end
         RUN: begin
            timer_n = '0;
            state_n = WAIT;
         end
         WAIT: begin
            // A done pulse on the final timer count still counts as success.
            if (unit_stop) begin
               rv_n    = 1'b1;
               rid_n   = gnt;
               rdata_n = unit_dout;
               state_n = DRAIN;
            end else if (timer == TW'(TIMEOUT-1)) begin
               rv_n    = 1'b1;
               re_n    = 1'b1;
               rid_n   = gnt;
               rdata_n = '0;
               state_n = DRAIN;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         DRAIN: begin
            if (!unit_busy)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         timer     <= '0;
         ack       <= '0;
         unit_run  <= 1'b0;
         unit_din  <= '0;
         res_valid <= 1'b0;
         res_err   <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
         arb_busy  <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         gnt       <= gnt_n;
         timer     <= timer_n;
         ack       <= ack_n;
         unit_run  <= run_n;
         unit_din  <= din_n;
         res_valid <= rv_n;
         res_err   <= re_n;
         res_id    <= rid_n;
         res_data  <= rdata_n;
         arb_busy  <= busy_n;
      end
   end

endmodule

// File: tb/tb_sec_arbiter.sv
// tb/tb_sec_arbiter.sv - self-checking bench for sec_arbiter with a shared-unit model
// A transaction-level reference model predicts every output each cycle; directed tests pin literals.
module tb_sec_arbiter;
   localparam int NB = 16;
   localparam int NR = 4;
   localparam int TO = NB/2 + 16;
   localparam int NO = NB/2;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [NR-1:0]      req = '0;
   logic [NR*NB-1:0]   req_data = '0;
   logic [NR-1:0]      ack;
   logic               res_valid, res_err, arb_busy, unit_run;
   logic [2:0]         res_id;
   logic [NO-1:0]      res_data;
   logic [NB-1:0]      unit_din;
   logic               unit_busy, unit_stop;
   logic [NO-1:0]      unit_dout = '0;
   logic               u_busy = 1'b0, f_busy = 1'b0, u_stop = 1'b0, x_stop = 1'b0;
   logic [NB-1:0]      u_din = '0;
   int                 u_cnt = 0;
   int                 lat = 12;
   int                 total = 0, bad = 0, cyc = 0;
   bit                 chk_en = 1'b0;

   assign unit_busy = u_busy | f_busy;
   assign unit_stop = u_stop | x_stop;

   sec_arbiter #(.NBITSIN(NB), .NREQ(NR), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .req(req), .req_data(req_data),
      .ack(ack), .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
      .res_err(res_err), .arb_busy(arb_busy), .unit_run(unit_run), .unit_din(unit_din),
      .unit_busy(unit_busy), .unit_stop(unit_stop), .unit_dout(unit_dout)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Shared-unit model: done pulse 'lat' cycles after the start pulse; lat=0 means it never answers.
   always @(negedge clock) begin
      if (reset) begin
         u_busy = 1'b0; u_stop = 1'b0; u_cnt = 0;
      end else if (u_stop) begin
         u_stop = 1'b0; u_busy = 1'b0;
      end else if (unit_run && lat > 0) begin
         u_busy = 1'b1; u_cnt = lat; u_din = unit_din;
      end else if (u_busy) begin
         if (u_cnt == 1) begin
            u_stop = 1'b1; unit_dout = u_din[NO-1:0] ^ 8'h58;
         end else begin
            u_cnt--;
         end
      end
   end

   // Reference model: m_age counts WAIT cycles elapsed since the grant (0 = the RUN cycle).
   int              m_ptr = 0, m_cur = 0, m_age = -1;
   bit              m_drain = 1'b0;
   logic [NR-1:0]   e_ack = '0;
   logic            e_run = 1'b0, e_rv = 1'b0, e_re = 1'b0, e_busy = 1'b0;
   logic [NB-1:0]   e_din = '0;
   logic [2:0]      e_rid = '0;
   logic [NO-1:0]   e_rdata = '0;

   always @(posedge clock) begin
      cyc++;
      e_ack = '0; e_run = 1'b0; e_rv = 1'b0; e_re = 1'b0;
      if (reset) begin
         m_ptr = 0; m_age = -1; m_drain = 1'b0;
         e_din = '0; e_rid = '0; e_rdata = '0;
      end else if (m_drain) begin
         if (!unit_busy) m_drain = 1'b0;
      end else if (m_age < 0) begin
         if (!unit_busy)
            for (int k = 0; k < NR; k++)
               if (m_age < 0 && req[(m_ptr + k) % NR]) begin
                  m_cur = (m_ptr + k) % NR;
                  m_ptr = (m_cur + 1) % NR;
                  e_ack = NR'(1) << m_cur;
                  e_run = 1'b1;
                  e_din = req_data[m_cur*NB +: NB];
                  m_age = 0;
               end
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (unit_stop) begin
         e_rv = 1'b1; e_rid = 3'(m_cur); e_rdata = unit_dout;
         m_age = -1; m_drain = 1'b1;
      end else if (m_age == TO) begin
         e_rv = 1'b1; e_re = 1'b1; e_rid = 3'(m_cur); e_rdata = '0;
         m_age = -1; m_drain = 1'b1;
      end else begin
         m_age++;
      end
      e_busy = m_drain || (m_age >= 0);
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("ack", ack, e_ack);
         check("unit_run", unit_run, e_run);
         check("unit_din", unit_din, e_din);
         check("res_valid", res_valid, e_rv);
         check("res_err", res_err, e_re);
         check("res_id", res_id, e_rid);
         check("res_data", res_data, e_rdata);
         check("arb_busy", arb_busy, e_busy);
      end
   end

   task automatic wait_ack(input int bound, output int idx, output int n);
      n = 0; idx = -1;
      do begin @(negedge clock); n++; end while (ack == '0 && n < bound);
      check("ack_seen", (ack != '0), 1);
      for (int i = 0; i < NR; i++) if (ack[i]) idx = i;
   endtask

   task automatic wait_res(input int bound, output int n);
      n = 0;
      do begin @(negedge clock); n++; end while (!res_valid && n < bound);
      check("res_seen", res_valid, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (arb_busy && n < 100) begin @(negedge clock); n++; end
      check("idle_reached", arb_busy, 0);
      @(negedge clock);
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};
   int idx, n, nres;

   initial begin
      for (int i = 0; i < NR; i++) req_data[i*NB +: NB] = 16'h0051 + 16'(i * 16'h0111);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("rst_ack", ack, 0);
      check("rst_busy", arb_busy, 0);
      check("rst_din", unit_din, 0);
      check("rst_rv", res_valid, 0);
      chk_en = 1'b1;
      @(negedge clock);

      // Fairness with all requesters held.
      lat = 1;
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_ack(20, idx, n);
         check("fair_order", idx, exp_order[j]);
         if (j > 0) check("fair_spacing", n, 4);
      end
      req = '0;
      wait_idle();

      // Single request; requester drops req after its ack.
      lat = 12;
      req = 4'b0001;
      wait_ack(20, idx, n);
      check("single_ack", ack, 4'b0001);
      check("single_run", unit_run, 1);
      check("single_din", unit_din, 16'h0051);
      req = '0;
      wait_res(40, n);
      check("single_lat", n, 13);
      check("single_id", res_id, 0);
      check("single_data", res_data, 8'h09);
      check("single_err", res_err, 0);
      wait_idle();

      // Pointer: grant 2, then 0 and 2 request -> 0 wins (search 3,0).
      lat = 2;
      req = 4'b0100;
      wait_ack(20, idx, n);
      check("ptr_first", idx, 2);
      req = 4'b0101;
      wait_ack(20, idx, n);
      check("ptr_next", idx, 0);
      req = '0;
      wait_idle();

      // Timeout with a unit that never answers.
      lat = 0;
      req = 4'b0010;
      wait_ack(20, idx, n);
      req = '0;
      wait_res(60, n);
      check("to_lat", n, 25);
      check("to_err", res_err, 1);
      check("to_data", res_data, 0);
      check("to_id", res_id, 1);
      wait_idle();

      // Done pulse on the last timer count wins over timeout.
      lat = 24;
      req = 4'b0001;
      wait_ack(20, idx, n);
      req = '0;
      wait_res(60, n);
      check("edge_lat", n, 25);
      check("edge_err", res_err, 0);
      check("edge_data", res_data, 8'h09);
      wait_idle();

      // Done pulse one cycle late lands in DRAIN and is ignored.
      lat = 25;
      req = 4'b0001;
      wait_ack(20, idx, n);
      req = '0;
      wait_res(60, n);
      check("late_err", res_err, 1);
      check("late_data", res_data, 0);
      wait_idle();

      // Stray done pulse while idle.
      x_stop = 1'b1;
      @(negedge clock);
      x_stop = 1'b0;
      @(negedge clock);
      check("stray_rv", res_valid, 0);

      // Busy unit blocks the grant.
      lat = 3;
      f_busy = 1'b1;
      req = 4'b0010;
      for (int j = 0; j < 5; j++) begin
         @(negedge clock);
         check("busy_block_ack", ack, 0);
      end
      f_busy = 1'b0;
      @(negedge clock);
      check("busy_release_ack", ack, 4'b0010);
      req = '0;
      wait_idle();

      // Reset in the middle of WAIT.
      lat = 0;
      req = 4'b0100;
      wait_ack(20, idx, n);
      req = '0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("wrst_ack", ack, 0);
      check("wrst_run", unit_run, 0);
      check("wrst_din", unit_din, 0);
      check("wrst_rv", res_valid, 0);
      check("wrst_err", res_err, 0);
      check("wrst_id", res_id, 0);
      check("wrst_data", res_data, 0);
      check("wrst_busy", arb_busy, 0);
      nres = 0;
      repeat (30) begin @(negedge clock); if (res_valid) nres++; end
      check("wrst_no_result", nres, 0);
      lat = 1;
      req = 4'b1111;
      wait_ack(20, idx, n);
      check("wrst_next_grant", idx, 0);
      req = '0;
      wait_idle();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
